// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-address defaults and the R0 index.
package hazard_ctrl_pkg;

    localparam int REG_W_DEF      = 4;
    localparam int MD_LATENCY_DEF = 4;
    localparam int R0_IDX         = 0;
    localparam int PERF_W         = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of saturating 16-bit event counters (stall cycles, taken-branch flushes).
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_inc,
    input  logic              i_flush_inc,
    output logic [PERF_W-1:0] o_stall_cycles,
    output logic [PERF_W-1:0] o_flush_count
);

    logic [1:0]        w_inc;
    logic [PERF_W-1:0] r_cnt [2];

    assign w_inc = {i_flush_inc, i_stall_inc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_inc[gi] && (r_cnt[gi] != {PERF_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign o_stall_cycles = r_cnt[0];
    assign o_flush_count  = r_cnt[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle muldiv hold. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int REG_W      = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] bIFID_RR1,
    input  logic [REG_W-1:0] bIFID_RR2,
    input  logic [REG_W-1:0] bIDEX_RR1,
    input  logic             bIDEX_memRead,
    input  logic             bIDEX_muldiv,
    input  logic             branch_taken,
    output logic             pcWrite,
    output logic             bIFID_write,
    output logic             bIFID_flush,
    output logic             bIDEX_write,
    output logic             bIDEX_flush,
    output logic             bEXMEM_bubble,
    output logic             md_start,
    output logic             md_done,
    output logic             md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    localparam int CNT_W = $clog2(MD_LATENCY);

    hz_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_use;

    assign w_load_use = bIDEX_memRead
                     && (bIDEX_RR1 != REG_W'(R0_IDX))
                     && ((bIDEX_RR1 == bIFID_RR1) || (bIDEX_RR1 == bIFID_RR2));

    // Branch outranks muldiv: a muldiv squashed by the branch must not start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!branch_taken && bIDEX_muldiv) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= CNT_W'(MD_LATENCY - 2);
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        pcWrite       = 1'b1;
        bIFID_write   = 1'b1;
        bIFID_flush   = 1'b0;
        bIDEX_write   = 1'b1;
        bIDEX_flush   = 1'b0;
        bEXMEM_bubble = 1'b0;
        md_start      = 1'b0;
        md_done       = 1'b0;
        md_busy       = 1'b0;
        if (rst) begin
            pcWrite       = 1'b0;
            bIFID_write   = 1'b0;
            bIDEX_write   = 1'b0;
            bIFID_flush   = 1'b1;
            bIDEX_flush   = 1'b1;
            bEXMEM_bubble = 1'b1;
        end else if (r_state == RUN) begin
            if (branch_taken) begin
                bIFID_flush = 1'b1;
                bIDEX_flush = 1'b1;
            end else if (bIDEX_muldiv) begin
                md_start      = 1'b1;
                md_busy       = 1'b1;
                pcWrite       = 1'b0;
                bIFID_write   = 1'b0;
                bIDEX_write   = 1'b0;
                bEXMEM_bubble = 1'b1;
            end else if (w_load_use) begin
                pcWrite     = 1'b0;
                bIFID_write = 1'b0;
                bIDEX_flush = 1'b1;
            end
        end else begin
            md_busy = 1'b1;
            if (r_cnt != '0) begin
                pcWrite       = 1'b0;
                bIFID_write   = 1'b0;
                bIDEX_write   = 1'b0;
                bEXMEM_bubble = 1'b1;
            end else begin
                md_done = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = !rst && !pcWrite;
    assign w_flush_inc = !rst && (r_state == RUN) && branch_taken;

    hazard_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .i_stall_inc    (w_stall_inc),
        .i_flush_inc    (w_flush_inc),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU; companion to the forwarding logic.
- Generates PC/IF-ID/ID-EX write enables, stage flushes and bubbles for three cases: load-use hazards, taken branches, and a multi-cycle multiply/divide unit in EX that holds the pipeline.
- Muldiv writes its secondary result to R0 (regWrite0 path); this block times the start/done pulses for that unit.

Parameters:
- MD_LATENCY, 4, total cycles a muldiv instruction occupies EX, including the start cycle; legal range 2..16.
- REG_W, 4, register address width (16 registers; R0 special).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- bIFID_RR1  in  REG_W  first source register of the instruction in ID.
- bIFID_RR2  in  REG_W  second source register of the instruction in ID.
- bIDEX_RR1  in  REG_W  destination register of the instruction in EX.
- bIDEX_memRead  in  1  EX instruction is a load.
- bIDEX_muldiv  in  1  EX instruction is a multiply/divide.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- pcWrite  out  1  PC load enable.
- bIFID_write  out  1  IF/ID register enable.
- bIFID_flush  out  1  IF/ID cleared to NOP.
- bIDEX_write  out  1  ID/EX register enable.
- bIDEX_flush  out  1  ID/EX cleared to bubble.
- bEXMEM_bubble  out  1  EX/MEM loads bubble instead of the EX result.
- md_start  out  1  one-cycle pulse that starts the muldiv unit.
- md_done  out  1  one-cycle pulse; the muldiv result is valid and its R0 write proceeds.
- md_busy  out  1  high in every muldiv-occupied EX cycle.

Behaviour:
- States: RUN, MD_BUSY. Down-counter cnt with width clog2(MD_LATENCY).
- Outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Reset (rst=1, sampled at posedge): state=RUN, cnt=0. While rst is high the outputs are pcWrite=0, bIFID_write=0, bIDEX_write=0, bIFID_flush=1, bIDEX_flush=1, bEXMEM_bubble=1, and md_start, md_done, md_busy all 0.
- Default in RUN: pcWrite=1, bIFID_write=1, bIDEX_write=1; all flush, bubble and md signals are 0.
- RUN priority (highest first):
  - 1) branch_taken: bIFID_flush=1, bIDEX_flush=1, pcWrite=1. bIDEX_muldiv is ignored that cycle.
  - 2) bIDEX_muldiv: md_start=1, md_busy=1, pcWrite=0, bIFID_write=0, bIDEX_write=0, bEXMEM_bubble=1. Next state is MD_BUSY with cnt=MD_LATENCY-2.
  - 3) Load-use: bIDEX_memRead && bIDEX_RR1!=0 && (bIDEX_RR1==bIFID_RR1 || bIDEX_RR1==bIFID_RR2). Response: pcWrite=0, bIFID_write=0, bIDEX_flush=1, for exactly one cycle. The next cycle re-evaluates, and since the load has left EX the stall clears.
- MD_BUSY:
  - md_busy=1 every cycle.
  - cnt>0: hold everything (pcWrite=0, bIFID_write=0, bIDEX_write=0, bEXMEM_bubble=1); cnt decrements.
  - cnt==0: release cycle. md_done=1, bEXMEM_bubble=0, and all write enables are 1. Next state is RUN.
  - branch_taken and load-use inputs are ignored in MD_BUSY.
- Total front-end stall per muldiv = MD_LATENCY-1 cycles. MD_LATENCY=2 goes start cycle, then release cycle.
- Load loading R0 (bIDEX_RR1=0) never stalls.
- rst mid-MD_BUSY: returns to RUN, and md_done is not emitted.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[15:0] and flush_count[15:0].
  - stall_cycles increments on every cycle with pcWrite=0 and rst=0.
  - flush_count increments on every taken-branch flush.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (RUN=1'b0, MD_BUSY=1'b1), REG_W, R0 index constant, MD_LATENCY default.
- One natural sub-module: hazard_perf_cnt (saturating counter pair), instantiated only under HAZARD_PERF_EN.

Test Plan:
- Reset: rst=1 for 2 cycles → pcWrite=0, both flushes=1, bEXMEM_bubble=1. First cycle after rst falls, no hazard inputs → pcWrite=1, bIFID_write=1, bIDEX_write=1.
- Load-use: bIDEX_memRead=1, bIDEX_RR1=5, bIFID_RR2=5 → exactly one cycle of pcWrite=0, bIFID_write=0, bIDEX_flush=1. Repeat with bIDEX_RR1=0 → no stall.
- Muldiv, MD_LATENCY=4: bIDEX_muldiv=1 at cycle t → md_start at t; stall at t, t+1, t+2; md_done=1 and writes resume at t+3; md_busy high t..t+3.
- Branch and muldiv together in RUN: branch_taken=1 and bIDEX_muldiv=1 → flushes asserted, md_start=0, state stays RUN.
- Reset mid-muldiv: rst=1 at t+1 of a muldiv → md_done never pulses; RUN defaults appear on the first cycle after rst drops.
- HAZARD_PERF_EN: run 3 load-use stalls and 2 branches → stall_cycles=3, flush_count=2. Force stall_cycles to 16'hFFFF, add one more stall → value stays 16'hFFFF.
